approx_adder_err_monitor: RTL and testbench

- Hardware self-test stage wrapped around an 8-bit approximate adder under test (DUT).
- Upstream role: issues every (a, b) operand pair exhaustively to the DUT.
- Downstream role: consumes the DUT sum, compares it with the exact sum, and accumulates error metrics (error cases, total error distance, max error, worst-case operands).
- Software derives ER and MED from the counters, so FPGA runs need no simulator.

---
 rtl/approx_mon_pkg.sv | 20 ++
 rtl/approx_sweep_gen.sv | 70 +++++++
 rtl/approx_adder_err_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mon_pkg.sv
// -----------------------------------------------------------------------------
// approx_mon_pkg
// Shared types and default parameters for the approximate-adder error monitor.
//   mon_state_e : monitor FSM states (idle, sweep issuing, pipeline drain, done)
//   DEF_*       : default operand width, DUT latency and error-accumulator width
// -----------------------------------------------------------------------------
package approx_mon_pkg;

    localparam int unsigned DEF_W       = 8;
    localparam int unsigned DEF_DUT_LAT = 0;
    localparam int unsigned DEF_ACC_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/approx_sweep_gen.sv
// -----------------------------------------------------------------------------
// approx_sweep_gen
// Exhaustive operand generator: b is the inner counter, a the outer, starting
// at (0,0) and ending at (2^W-1, 2^W-1), one vector per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   go_i       : start a fresh sweep at (0,0) on this edge
//   a_o, b_o   : current operands (hold the last vector once the sweep ends)
//   valid_o    : a vector is being issued this cycle
//   last_o     : the vector issued this cycle is the final one
// -----------------------------------------------------------------------------
module approx_sweep_gen
    import approx_mon_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic         valid_o,
    output logic         last_o
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         active_q, active_d;

    assign last_o  = active_q && (a_q == '1) && (b_q == '1);
    assign valid_o = active_q;
    assign a_o     = a_q;
    assign b_o     = b_q;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        active_d = active_q;
        if (go_i) begin
            a_d      = '0;
            b_d      = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (last_o) begin
                active_d = 1'b0;        // operands hold the final vector
            end else begin
                b_d = b_q + W'(1);
                if (b_q == '1) begin
                    a_d = a_q + W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            active_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/approx_adder_err_monitor.sv
// -----------------------------------------------------------------------------
// approx_adder_err_monitor
// Self-test wrapper for a W-bit approximate adder. Sweeps every (a,b) pair,
// scores each returned sum against the exact sum and accumulates error metrics.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a sweep (ignored while busy)
//   a_out, b_out   : operands to the adder under test
//   approx_sum_in  : adder sum, valid DUT_LAT cycles after the operands
//   busy, done     : sweep/drain in progress, results final
//   total_cases    : vectors scored
//   error_cases    : vectors with nonzero error
//   total_err      : saturating sum of |exact - approx|; acc_ovf marks saturation
//   max_err        : largest single error; worst_a/worst_b its first operands
// -----------------------------------------------------------------------------
module approx_adder_err_monitor
    import approx_mon_pkg::*;
#(
    parameter int unsigned W       = DEF_W,
    parameter int unsigned DUT_LAT = DEF_DUT_LAT,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned CNT_W   = 2 * W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    input  logic [W:0]       approx_sum_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] total_cases,
    output logic [CNT_W-1:0] error_cases,
    output logic [ACC_W-1:0] total_err,
    output logic             acc_ovf,
    output logic [W:0]       max_err,
    output logic [W-1:0]     worst_a,
    output logic [W-1:0]     worst_b
);

    localparam int unsigned DRN_W = $clog2(DUT_LAT + 2);
    localparam int unsigned PW    = 1 + (W + 1) + 2 * W;   // {valid, exact, a, b}

    mon_state_e       state_q, state_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic             go;

    logic [W-1:0]     gen_a, gen_b;
    logic             gen_valid, gen_last;

    // A sweep may only be launched from a quiescent state.
    assign go = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    approx_sweep_gen #(.W(W)) u_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .go_i    (go),
        .a_o     (gen_a),
        .b_o     (gen_b),
        .valid_o (gen_valid),
        .last_o  (gen_last)
    );

    assign a_out = gen_a;
    assign b_out = gen_b;
    assign busy  = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign done  = (state_q == ST_DONE);

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (gen_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                // DUT_LAT+1 drain cycles cover the DUT delay plus stage E.
                if (drain_q == DRN_W'(DUT_LAT)) state_d = ST_DONE;
                else                            drain_d = drain_q + DRN_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // ---------------- Delay line aligning the reference with the DUT ----------------
    logic [W:0]    issue_exact;
    logic [PW-1:0] issue_word, dly_word;
    logic          d_valid;
    logic [W:0]    d_exact;
    logic [W-1:0]  d_a, d_b;

    assign issue_exact = {1'b0, gen_a} + {1'b0, gen_b};
    assign issue_word  = {gen_valid, issue_exact, gen_a, gen_b};

    generate
        if (DUT_LAT == 0) begin : g_no_dly
            assign dly_word = issue_word;
        end else begin : g_dly
            logic [PW-1:0] dly_q [DUT_LAT];

            // NOTE: the delay line is reset, not left uninitialised like a RAM,
            // because a stale valid bit would be scored as a vector.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DUT_LAT; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= issue_word;
                    for (int i = 1; i < DUT_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign dly_word = dly_q[DUT_LAT-1];
        end
    endgenerate

    assign {d_valid, d_exact, d_a, d_b} = dly_word;

    // ---------------- Stage E: error distance ----------------
    logic         err_valid_q;
    logic [W:0]   err_q;
    logic [W-1:0] err_a_q, err_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_q       <= '0;
            err_a_q     <= '0;
            err_b_q     <= '0;
        end else begin
            err_valid_q <= d_valid;
            if (d_valid) begin
                err_q   <= (d_exact >= approx_sum_in) ? (d_exact - approx_sum_in)
                                                      : (approx_sum_in - d_exact);
                err_a_q <= d_a;
                err_b_q <= d_b;
            end
        end
    end

    // ---------------- Stage A: accumulation ----------------
    logic [CNT_W-1:0] total_cases_q, total_cases_d;
    logic [CNT_W-1:0] error_cases_q, error_cases_d;
    logic [ACC_W-1:0] total_err_q, total_err_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [W:0]       max_err_q, max_err_d;
    logic [W-1:0]     worst_a_q, worst_a_d;
    logic [W-1:0]     worst_b_q, worst_b_d;
    logic [ACC_W:0]   err_sum;

    always_comb begin
        total_cases_d = total_cases_q;
        error_cases_d = error_cases_q;
        total_err_d   = total_err_q;
        acc_ovf_d     = acc_ovf_q;
        max_err_d     = max_err_q;
        worst_a_d     = worst_a_q;
        worst_b_d     = worst_b_q;
        // One extra bit exposes the carry that signals saturation.
        err_sum       = {1'b0, total_err_q} + (ACC_W+1)'(err_q);
        if (go) begin
            total_cases_d = '0;
            error_cases_d = '0;
            total_err_d   = '0;
            acc_ovf_d     = 1'b0;
            max_err_d     = '0;
            worst_a_d     = '0;
            worst_b_d     = '0;
        end else if (err_valid_q) begin
            total_cases_d = total_cases_q + CNT_W'(1);
            if (err_q != '0) error_cases_d = error_cases_q + CNT_W'(1);
            if (err_sum[ACC_W]) begin
                total_err_d = '1;
                acc_ovf_d   = 1'b1;
            end else begin
                total_err_d = err_sum[ACC_W-1:0];
            end
            // Strictly greater: ties keep the earliest vector.
            if (err_q > max_err_q) begin
                max_err_d = err_q;
                worst_a_d = err_a_q;
                worst_b_d = err_b_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cases_q <= '0;
            error_cases_q <= '0;
            total_err_q   <= '0;
            acc_ovf_q     <= 1'b0;
            max_err_q     <= '0;
            worst_a_q     <= '0;
            worst_b_q     <= '0;
        end else begin
            total_cases_q <= total_cases_d;
            error_cases_q <= error_cases_d;
            total_err_q   <= total_err_d;
            acc_ovf_q     <= acc_ovf_d;
            max_err_q     <= max_err_d;
            worst_a_q     <= worst_a_d;
            worst_b_q     <= worst_b_d;
        end
    end

    assign total_cases = total_cases_q;
    assign error_cases = error_cases_q;
    assign total_err   = total_err_q;
    assign acc_ovf     = acc_ovf_q;
    assign max_err     = max_err_q;
    assign worst_a     = worst_a_q;
    assign worst_b     = worst_b_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// -----------------------------------------------------------------------------
// Bench for approx_adder_err_monitor. Five monitors share clock, reset and
// start, each wrapped around a different adder stub:
//   ex : exact adder, DUT_LAT=0
//   lb : sum[0] forced 0
//   mb : sum[8] forced 0
//   st : sum[8] forced 0, ACC_W=16 (accumulator saturates)
//   l2 : sum[8] forced 0, registered twice, DUT_LAT=2
// -----------------------------------------------------------------------------
module tb_approx_adder_err_monitor;

    localparam int MID_A  = 8'h10;    // operand A at which the mid-sweep reset fires
    localparam int BUDGET = 70000;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- exact stub ----------------
    logic [7:0]  ex_a, ex_b, ex_wa, ex_wb;
    logic [8:0]  ex_sum, ex_me;
    logic        ex_busy, ex_done, ex_ovf;
    logic [16:0] ex_tc, ex_ec;
    logic [31:0] ex_te;
    assign ex_sum = {1'b0, ex_a} + {1'b0, ex_b};

    approx_adder_err_monitor u_ex (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(ex_a), .b_out(ex_b),
        .approx_sum_in(ex_sum), .busy(ex_busy), .done(ex_done), .total_cases(ex_tc),
        .error_cases(ex_ec), .total_err(ex_te), .acc_ovf(ex_ovf), .max_err(ex_me),
        .worst_a(ex_wa), .worst_b(ex_wb)
    );

    // ---------------- sum[0] forced 0 ----------------
    logic [7:0]  lb_a, lb_b, lb_wa, lb_wb;
    logic [8:0]  lb_full, lb_sum, lb_me;
    logic        lb_busy, lb_done, lb_ovf;
    logic [16:0] lb_tc, lb_ec;
    logic [31:0] lb_te;
    assign lb_full = {1'b0, lb_a} + {1'b0, lb_b};
    assign lb_sum  = {lb_full[8:1], 1'b0};

    approx_adder_err_monitor u_lb (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(lb_a), .b_out(lb_b),
        .approx_sum_in(lb_sum), .busy(lb_busy), .done(lb_done), .total_cases(lb_tc),
        .error_cases(lb_ec), .total_err(lb_te), .acc_ovf(lb_ovf), .max_err(lb_me),
        .worst_a(lb_wa), .worst_b(lb_wb)
    );

    // ---------------- sum[8] forced 0 ----------------
    logic [7:0]  mb_a, mb_b, mb_wa, mb_wb;
    logic [8:0]  mb_full, mb_sum, mb_me;
    logic        mb_busy, mb_done, mb_ovf;
    logic [16:0] mb_tc, mb_ec;
    logic [31:0] mb_te;
    assign mb_full = {1'b0, mb_a} + {1'b0, mb_b};
    assign mb_sum  = {1'b0, mb_full[7:0]};

    approx_adder_err_monitor u_mb (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(mb_a), .b_out(mb_b),
        .approx_sum_in(mb_sum), .busy(mb_busy), .done(mb_done), .total_cases(mb_tc),
        .error_cases(mb_ec), .total_err(mb_te), .acc_ovf(mb_ovf), .max_err(mb_me),
        .worst_a(mb_wa), .worst_b(mb_wb)
    );

    // ---------------- sum[8] forced 0, 16-bit accumulator ----------------
    logic [7:0]  st_a, st_b, st_wa, st_wb;
    logic [8:0]  st_full, st_sum, st_me;
    logic        st_busy, st_done, st_ovf;
    logic [16:0] st_tc, st_ec;
    logic [15:0] st_te;
    assign st_full = {1'b0, st_a} + {1'b0, st_b};
    assign st_sum  = {1'b0, st_full[7:0]};

    approx_adder_err_monitor #(.ACC_W(16)) u_st (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(st_a), .b_out(st_b),
        .approx_sum_in(st_sum), .busy(st_busy), .done(st_done), .total_cases(st_tc),
        .error_cases(st_ec), .total_err(st_te), .acc_ovf(st_ovf), .max_err(st_me),
        .worst_a(st_wa), .worst_b(st_wb)
    );

    // ---------------- sum[8] forced 0, two register stages ----------------
    logic [7:0]  l2_a, l2_b, l2_wa, l2_wb;
    logic [8:0]  l2_full, l2_r1, l2_r2, l2_me;
    logic        l2_busy, l2_done, l2_ovf;
    logic [16:0] l2_tc, l2_ec;
    logic [31:0] l2_te;
    assign l2_full = {1'b0, l2_a} + {1'b0, l2_b};
    always @(posedge clk) begin
        l2_r1 <= {1'b0, l2_full[7:0]};
        l2_r2 <= l2_r1;
    end

    approx_adder_err_monitor #(.DUT_LAT(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(l2_a), .b_out(l2_b),
        .approx_sum_in(l2_r2), .busy(l2_busy), .done(l2_done), .total_cases(l2_tc),
        .error_cases(l2_ec), .total_err(l2_te), .acc_ovf(l2_ovf), .max_err(l2_me),
        .worst_a(l2_wa), .worst_b(l2_wb)
    );

    // Cycle (counted from the start-sampling edge) at which each done rose.
    int ex_done_at = -1, l2_done_at = -1, lb_done_at = -1, mb_done_at = -1, st_done_at = -1;
    logic ex_busy_at_done, l2_busy_at_done;

    // ---------------- tests ----------------
    task automatic test_reset();
        n_cmp++; if (ex_busy !== 1'b0 || ex_done !== 1'b0) begin n_err++;
            $display("FAIL reset_ex_flags: busy=%b done=%b expected 0 0", ex_busy, ex_done); end
        n_cmp++; if (ex_a !== 8'd0 || ex_b !== 8'd0) begin n_err++;
            $display("FAIL reset_ex_ops: a=%0d b=%0d expected 0 0", ex_a, ex_b); end
        n_cmp++; if (ex_tc !== 17'd0 || ex_ec !== 17'd0 || ex_te !== 32'd0) begin n_err++;
            $display("FAIL reset_ex_counts: tc=%0d ec=%0d te=%0d expected 0", ex_tc, ex_ec, ex_te); end
        n_cmp++; if (ex_ovf !== 1'b0 || ex_me !== 9'd0 || ex_wa !== 8'd0 || ex_wb !== 8'd0) begin n_err++;
            $display("FAIL reset_ex_max: ovf=%b me=%0d wa=%0d wb=%0d expected 0", ex_ovf, ex_me, ex_wa, ex_wb); end
    endtask

    task automatic test_mid_sweep_reset();
        int k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (ex_a !== MID_A[7:0] && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++; if (ex_a !== MID_A[7:0]) begin n_err++;
            $display("FAIL mid_reach: a=%0d expected %0d within budget", ex_a, MID_A); end
        n_cmp++; if (mb_ec === 17'd0) begin n_err++;
            $display("FAIL mid_pre_errors: mb error_cases=%0d expected nonzero", mb_ec); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ex_a !== 8'd0 || ex_b !== 8'd0 || ex_busy !== 1'b0 || ex_done !== 1'b0) begin n_err++;
            $display("FAIL mid_ex_state: a=%0d b=%0d busy=%b done=%b expected 0", ex_a, ex_b, ex_busy, ex_done); end
        n_cmp++; if (mb_tc !== 17'd0 || mb_ec !== 17'd0 || mb_te !== 32'd0 || mb_ovf !== 1'b0) begin n_err++;
            $display("FAIL mid_mb_counts: tc=%0d ec=%0d te=%0d ovf=%b expected 0", mb_tc, mb_ec, mb_te, mb_ovf); end
        n_cmp++; if (mb_me !== 9'd0 || mb_wa !== 8'd0 || mb_wb !== 8'd0) begin n_err++;
            $display("FAIL mid_mb_max: me=%0d wa=%0d wb=%0d expected 0", mb_me, mb_wa, mb_wb); end
        n_cmp++; if (l2_busy !== 1'b0 || st_busy !== 1'b0 || lb_busy !== 1'b0) begin n_err++;
            $display("FAIL mid_busy: l2=%b st=%b lb=%b expected 0", l2_busy, st_busy, lb_busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ex_busy !== 1'b0 || ex_a !== 8'd0) begin n_err++;
            $display("FAIL mid_after_release: busy=%b a=%0d expected 0 0", ex_busy, ex_a); end
    endtask

    // Full sweep: checks vector order, start-while-busy, and records done timing.
    task automatic test_sweep();
        int cnt;
        logic [15:0] idx;
        start = 1'b1;
        @(posedge clk); #1;          // start sampled on this edge
        start = 1'b0;
        cnt = 0;
        while (cnt <= BUDGET) begin
            idx = 16'(cnt);
            if (cnt == 0 || cnt == 1 || cnt == 255 || cnt == 256 || cnt == 1001 || cnt == 65535) begin
                n_cmp++; if (ex_a !== idx[15:8] || ex_b !== idx[7:0] || ex_busy !== 1'b1) begin n_err++;
                    $display("FAIL sweep_vec_%0d: a=%0d b=%0d busy=%b expected %0d %0d 1",
                             cnt, ex_a, ex_b, ex_busy, idx[15:8], idx[7:0]); end
            end
            start = (cnt == 1000);   // one-cycle start pulse while busy
            if (cnt == 65536) begin
                n_cmp++; if (ex_busy !== 1'b1 || ex_done !== 1'b0) begin n_err++;
                    $display("FAIL drain_state: busy=%b done=%b expected 1 0", ex_busy, ex_done); end
            end
            if (ex_done === 1'b1 && ex_done_at < 0) begin ex_done_at = cnt; ex_busy_at_done = ex_busy; end
            if (l2_done === 1'b1 && l2_done_at < 0) begin l2_done_at = cnt; l2_busy_at_done = l2_busy; end
            if (lb_done === 1'b1 && lb_done_at < 0) lb_done_at = cnt;
            if (mb_done === 1'b1 && mb_done_at < 0) mb_done_at = cnt;
            if (st_done === 1'b1 && st_done_at < 0) st_done_at = cnt;
            if (ex_done_at >= 0 && l2_done_at >= 0 && lb_done_at >= 0 &&
                mb_done_at >= 0 && st_done_at >= 0) break;
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
    endtask

    task automatic test_timing();
        // done in cycle N+65538 (LAT 0) / N+65540 (LAT 2); cycle N+1+cnt after the start edge
        n_cmp++; if (ex_done_at != 65537 || ex_busy_at_done !== 1'b0) begin n_err++;
            $display("FAIL done_time_lat0: at=%0d busy=%b expected 65537 0", ex_done_at, ex_busy_at_done); end
        n_cmp++; if (l2_done_at != 65539 || l2_busy_at_done !== 1'b0) begin n_err++;
            $display("FAIL done_time_lat2: at=%0d busy=%b expected 65539 0", l2_done_at, l2_busy_at_done); end
        n_cmp++; if (lb_done_at != 65537 || mb_done_at != 65537 || st_done_at != 65537) begin n_err++;
            $display("FAIL done_time_others: lb=%0d mb=%0d st=%0d expected 65537", lb_done_at, mb_done_at, st_done_at); end
    endtask

    task automatic test_exact();
        n_cmp++; if (ex_tc !== 17'd65536 || ex_ec !== 17'd0) begin n_err++;
            $display("FAIL exact_counts: tc=%0d ec=%0d expected 65536 0", ex_tc, ex_ec); end
        n_cmp++; if (ex_te !== 32'd0 || ex_me !== 9'd0 || ex_ovf !== 1'b0) begin n_err++;
            $display("FAIL exact_err: te=%0d me=%0d ovf=%b expected 0 0 0", ex_te, ex_me, ex_ovf); end
    endtask

    task automatic test_lsb_err();
        n_cmp++; if (lb_tc !== 17'd65536 || lb_ec !== 17'd32768 || lb_te !== 32'd32768) begin n_err++;
            $display("FAIL lsb_counts: tc=%0d ec=%0d te=%0d expected 65536 32768 32768", lb_tc, lb_ec, lb_te); end
        n_cmp++; if (lb_me !== 9'd1 || lb_wa !== 8'd0 || lb_wb !== 8'd1) begin n_err++;
            $display("FAIL lsb_worst: me=%0d wa=%0d wb=%0d expected 1 0 1", lb_me, lb_wa, lb_wb); end
    endtask

    task automatic test_msb_err();
        n_cmp++; if (mb_tc !== 17'd65536 || mb_ec !== 17'd32640 || mb_te !== 32'd8355840 || mb_ovf !== 1'b0) begin n_err++;
            $display("FAIL msb_counts: tc=%0d ec=%0d te=%0d ovf=%b expected 65536 32640 8355840 0",
                     mb_tc, mb_ec, mb_te, mb_ovf); end
        n_cmp++; if (mb_me !== 9'd256 || mb_wa !== 8'd1 || mb_wb !== 8'd255) begin n_err++;
            $display("FAIL msb_worst: me=%0d wa=%0d wb=%0d expected 256 1 255", mb_me, mb_wa, mb_wb); end
    endtask

    task automatic test_saturation();
        n_cmp++; if (st_te !== 16'd65535 || st_ovf !== 1'b1) begin n_err++;
            $display("FAIL sat_acc: te=%0d ovf=%b expected 65535 1", st_te, st_ovf); end
        n_cmp++; if (st_tc !== 17'd65536 || st_ec !== 17'd32640 || st_me !== 9'd256 ||
                     st_wa !== 8'd1 || st_wb !== 8'd255) begin n_err++;
            $display("FAIL sat_other: tc=%0d ec=%0d me=%0d wa=%0d wb=%0d expected 65536 32640 256 1 255",
                     st_tc, st_ec, st_me, st_wa, st_wb); end
    endtask

    task automatic test_latency();
        n_cmp++; if (l2_tc !== 17'd65536 || l2_ec !== 17'd32640 || l2_te !== 32'd8355840 || l2_ovf !== 1'b0) begin n_err++;
            $display("FAIL lat2_counts: tc=%0d ec=%0d te=%0d ovf=%b expected 65536 32640 8355840 0",
                     l2_tc, l2_ec, l2_te, l2_ovf); end
        n_cmp++; if (l2_me !== 9'd256 || l2_wa !== 8'd1 || l2_wb !== 8'd255) begin n_err++;
            $display("FAIL lat2_worst: me=%0d wa=%0d wb=%0d expected 256 1 255", l2_me, l2_wa, l2_wb); end
    endtask

    task automatic test_hold();
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (ex_done !== 1'b1 || ex_busy !== 1'b0 || ex_a !== 8'hFF || ex_b !== 8'hFF) begin n_err++;
            $display("FAIL hold_state: done=%b busy=%b a=%0d b=%0d expected 1 0 255 255",
                     ex_done, ex_busy, ex_a, ex_b); end
        n_cmp++; if (mb_tc !== 17'd65536 || mb_te !== 32'd8355840 || l2_tc !== 17'd65536) begin n_err++;
            $display("FAIL hold_results: mb_tc=%0d mb_te=%0d l2_tc=%0d expected 65536 8355840 65536",
                     mb_tc, mb_te, l2_tc); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_mid_sweep_reset();
        test_sweep();
        test_timing();
        test_exact();
        test_lsb_err();
        test_msb_err();
        test_saturation();
        test_latency();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
